ovf_accumulator: RTL and testbench

- Streaming signed accumulator that sits directly downstream of the overflow-detecting adder stage.
- Accepts a frame of COUNT two's-complement operands over a valid/ready handshake and sums them in a WIDTH-bit register.
- Tracks a sticky overflow flag across the frame using the adder's sign rule.
- Presents the frame result on an output valid/ready handshake, then clears for the next frame.

---
 rtl/ovf_acc_pkg.sv | 22 ++
 rtl/ovf_add.sv | 22 ++
 rtl/ovf_accumulator.sv | 125 ++++++++++++
 tb/tb_ovf_accumulator.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ovf_acc_pkg.sv
// Shared types and limits for the overflow-tracking frame accumulator.
// Saturation limits are consumed only when OVF_ACC_SAT_EN is defined.
package ovf_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

    localparam int LIM_W = 64;

    // Largest positive WIDTH-bit two's-complement value, zero-extended.
    function automatic logic [LIM_W-1:0] smax(input int w);
        return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
    endfunction

    // Most negative WIDTH-bit value as a raw bit pattern (1 then zeros).
    function automatic logic [LIM_W-1:0] smin(input int w);
        return LIM_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/ovf_add.sv
// Combinational WIDTH-bit adder with carry-out and signed overflow.
// Overflow: operands share a sign and the sum's sign differs.
module ovf_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];
    assign of   = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/ovf_accumulator.sv
// Frame accumulator: sums COUNT signed operands with sticky overflow.
// Define OVF_ACC_SAT_EN to saturate on overflow instead of wrapping.
module ovf_accumulator
    import ovf_acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_of
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_e state_q;
    state_e state_d;

    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sticky;

    logic [WIDTH-1:0] sum;
    logic             ov;
    logic             add_cout_unused;
    logic [WIDTH-1:0] acc_nxt;
    logic             fire;
    logic             last;
    logic             out_hs;

    ovf_add #(
        .WIDTH(WIDTH)
    ) u_add (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (sum),
        .cout (add_cout_unused),
        .of   (ov)
    );

`ifdef OVF_ACC_SAT_EN
    localparam logic [LIM_W-1:0] MAX_L = smax(WIDTH);
    localparam logic [LIM_W-1:0] MIN_L = smin(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = MAX_L[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = MIN_L[WIDTH-1:0];

    // On overflow both operands share acc's sign, so it picks the limit.
    always_comb begin
        acc_nxt = sum;
        if (ov) begin
            acc_nxt = acc[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign acc_nxt = sum;
`endif

    assign in_ready = (state_q == ACC);
    assign fire     = in_valid && in_ready;
    assign last     = fire && (cnt == LAST);
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_hs) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_of    <= 1'b0;
        end else begin
            if (fire) begin
                acc    <= acc_nxt;
                sticky <= sticky | ov;
                cnt    <= cnt + CNT_W'(1);
            end
            if (last) begin
                out_sum   <= acc_nxt;
                out_of    <= sticky | ov;
                out_valid <= 1'b1;
            end
            // Result stays visible after the handshake; only state clears.
            if (out_hs) begin
                acc       <= '0;
                cnt       <= '0;
                sticky    <= 1'b0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ovf_accumulator.sv
// Directed bench for ovf_accumulator at WIDTH=4, COUNT=4.
// Expected values follow OVF_ACC_SAT_EN when it is defined.
module tb_ovf_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_of;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ovf_accumulator #(
        .WIDTH(4),
        .COUNT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_of    (out_of)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        check("in_ready_acc", in_ready, 1);
    endtask

    task automatic frame(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d,
                         input logic [3:0] es, input logic eo);
        send(a);
        send(b);
        send(c);
        send(d);
        @(negedge clk);
        in_valid = 1'b0;
        check("out_valid", out_valid, 1);
        check("out_sum", out_sum, es);
        check("out_of", out_of, eo);
        check("in_ready_done", in_ready, 0);
        @(negedge clk);
        check("in_ready_back", in_ready, 1);
        check("out_valid_clr", out_valid, 0);
        check("out_sum_hold", out_sum, es);
    endtask

    initial begin
        logic [3:0] pos_sum;
        logic [3:0] neg_sum;
        logic [3:0] bp_sum;
`ifdef OVF_ACC_SAT_EN
        pos_sum = 4'b0111;
        neg_sum = 4'b1100;
        bp_sum  = 4'b0111;
`else
        pos_sum = 4'b1011;
        neg_sum = 4'b1011;
        bp_sum  = 4'b0100;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_of", out_of, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        frame(4'b0001, 4'b0010, 4'b0011, 4'b0001, 4'b0111, 1'b0);
        frame(4'b0111, 4'b0100, 4'b0000, 4'b0000, pos_sum, 1'b1);
        frame(4'b1111, 4'b1000, 4'b0111, 4'b1101, neg_sum, 1'b1);

        // Backpressure with in_valid held high throughout DONE.
        out_ready = 1'b0;
        send(4'b0101);
        send(4'b0101);
        send(4'b0101);
        send(4'b0101);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_sum", out_sum, bp_sum);
            check("bp_out_of", out_of, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send(4'b0101);
        check("bp_out_valid_clr", out_valid, 0);
        send(4'b0001);
        send(4'b0000);
        send(4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_sum", out_sum, 4'b0110);
        check("bp_next_of", out_of, 0);
        @(negedge clk);

        // Reset in the middle of a frame with sticky already set.
        send(4'b0111);
        send(4'b0111);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        frame(4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
